// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// MEM-stage load/store request and response bundle.
interface dmem_if;
  logic        REQ_V;
  logic        REQ_WE;
  logic [1:0]  REQ_SIZE;
  logic        REQ_UNSIGNED;
  logic [63:0] REQ_ADDR;
  logic [63:0] REQ_WDATA;
  logic        FLUSH;
  logic        REQ_READY;
  logic        RESP_V;
  logic [63:0] RESP_RDATA;
  logic        MEM_LAM;
  logic        MEM_LAF;
  logic        MEM_SAM;
  logic        MEM_SAF;

  modport master (
    output REQ_V, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, FLUSH,
    input  REQ_READY, RESP_V, RESP_RDATA, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF
  );

  modport slave (
    input  REQ_V, REQ_WE, REQ_SIZE, REQ_UNSIGNED, REQ_ADDR, REQ_WDATA, FLUSH,
    output REQ_READY, RESP_V, RESP_RDATA, MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane merge for stores and lane extract/extend for loads on a 64-bit word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [63:0] old_word,
  input  logic [63:0] wdata,
  input  logic [2:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [63:0] merged_word,
  output logic [63:0] load_data
);

  logic [63:0] lane_mask;
  logic [63:0] raw;
  logic [5:0]  shift;

  always_comb begin
    lane_mask = '1;
    case (size)
      SIZE_B:  lane_mask = 64'h0000_0000_0000_00FF;
      SIZE_H:  lane_mask = 64'h0000_0000_0000_FFFF;
      SIZE_W:  lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = '1;
    endcase
    shift       = {offset, 3'b000};
    merged_word = (old_word & ~(lane_mask << shift)) | ((wdata & lane_mask) << shift);
    raw         = old_word >> shift;

    load_data = raw;
    case (size)
      SIZE_B:  load_data = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
      SIZE_H:  load_data = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
      SIZE_W:  load_data = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder: alignment/range checks, 64-bit word RAM,
// programmable response latency and one-cycle response pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input logic   CLK,
  input logic   RESET_N,
  dmem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e          state;
  logic [CW-1:0]   cnt;
  logic            ready_q;
  logic            resp_q;
  logic [63:0]     rdata_q;
  logic            lam_q, laf_q, sam_q, saf_q;

  logic [63:0]     ram [DEPTH_WORDS];
  logic [63:0]     off;
  logic [AW-1:0]   idx;
  logic [2:0]      align_mask;
  logic            misaligned;
  logic            fault;
  logic            accept;
  logic            do_write;
  logic [63:0]     old_word;
  logic [63:0]     merged_word;
  logic [63:0]     load_data;
  logic            resp_v;

  always_comb begin
    off        = bus.REQ_ADDR - BASE_ADDR;
    idx        = off[AW+2:3];
    align_mask = 3'(size_bytes(bus.REQ_SIZE) - 4'd1);
    misaligned = |(bus.REQ_ADDR[2:0] & align_mask);
    fault      = |off[63:AW+3];
    accept     = bus.REQ_V & ready_q & ~bus.FLUSH;
    do_write   = RESET_N & accept & bus.REQ_WE & ~misaligned & ~fault;
    old_word   = ram[idx];
  end

  dmem_lane_align u_align (
    .old_word    (old_word),
    .wdata       (bus.REQ_WDATA),
    .offset      (off[2:0]),
    .size        (bus.REQ_SIZE),
    .is_unsigned (bus.REQ_UNSIGNED),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  // Storage is deliberately outside the reset domain; the write is gated by RESET_N.
  always_ff @(posedge CLK) begin
    if (do_write) ram[idx] <= merged_word;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      lam_q   <= 1'b0;
      laf_q   <= 1'b0;
      sam_q   <= 1'b0;
      saf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          if (accept) begin
            ready_q <= 1'b0;
            if (misaligned | fault) begin
              state   <= RESP;
              resp_q  <= 1'b1;
              rdata_q <= '0;
              lam_q   <= ~bus.REQ_WE & misaligned;
              laf_q   <= ~bus.REQ_WE & ~misaligned & fault;
              sam_q   <=  bus.REQ_WE & misaligned;
              saf_q   <=  bus.REQ_WE & ~misaligned & fault;
            end else begin
              rdata_q <= bus.REQ_WE ? '0 : load_data;
              if (LATENCY == 1) begin
                state  <= RESP;
                resp_q <= 1'b1;
              end else begin
                state <= BUSY;
                cnt   <= CW'(LATENCY - 1);
              end
            end
          end
        end
        BUSY: begin
          if (bus.FLUSH) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            rdata_q <= '0;
          end else if (cnt == CW'(1)) begin
            state  <= RESP;
            resp_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          rdata_q <= '0;
          lam_q   <= 1'b0;
          laf_q   <= 1'b0;
          sam_q   <= 1'b0;
          saf_q   <= 1'b0;
        end
      endcase
    end
  end

  // FLUSH in RESP must kill the pulse in the very same cycle, hence the combinational gate.
  assign resp_v         = resp_q & ~bus.FLUSH;
  assign bus.REQ_READY  = ready_q;
  assign bus.RESP_V     = resp_v;
  assign bus.RESP_RDATA = rdata_q & {64{resp_v}};
  assign bus.MEM_LAM    = lam_q & resp_v;
  assign bus.MEM_LAF    = laf_q & resp_v;
  assign bus.MEM_SAM    = sam_q & resp_v;
  assign bus.MEM_SAF    = saf_q & resp_v;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the MEM stage load/store interface.
- Accepts one load/store request at a time from the MEM stage.
- Performs alignment and range checks, then reads or writes an internal 64-bit-word RAM after a programmable latency.
- Returns the extended load data, or exactly one of the LAM/LAF/SAM/SAF exception flags, with a one-cycle response pulse.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit words in the RAM; power of two.
- LATENCY, 2, cycles from request acceptance to RESP_V for in-range aligned accesses; must be ≥1.
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  synchronous active-low reset
- REQ_V  in  1  request valid
- REQ_WE  in  1  1 = store, 0 = load
- REQ_SIZE  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- REQ_UNSIGNED  in  1  load zero-extends when 1; ignored for stores and for doubles
- REQ_ADDR  in  64  byte address
- REQ_WDATA  in  64  store data, right-justified
- FLUSH  in  1  discard any pending response
- REQ_READY  out  1  responder can accept a request this cycle
- RESP_V  out  1  one-cycle response pulse
- RESP_RDATA  out  64  extended load data; 0 for stores and faults
- MEM_LAM  out  1  load address misaligned
- MEM_LAF  out  1  load access fault
- MEM_SAM  out  1  store address misaligned
- MEM_SAF  out  1  store access fault

Behaviour:
- Reset: while RESET_N = 0 at a posedge, state ← IDLE, counter ← 0, and all outputs ← 0 except REQ_READY. REQ_READY is 1 in IDLE. RAM contents are not reset.
- Reset mid-operation kills any pending response; a store already committed stays committed.
- Handshake: a request is accepted on a posedge with REQ_V & REQ_READY. REQ_READY = 1 only in IDLE, so there are no back-to-back accepts. All request fields are sampled at acceptance.
- Checks are evaluated at acceptance:
  - misaligned = (REQ_ADDR mod 2^REQ_SIZE) ≠ 0.
  - off = REQ_ADDR − BASE_ADDR, 64-bit unsigned.
  - fault = off ≥ DEPTH_WORDS*8. Wraparound below BASE_ADDR therefore faults.
  - Misaligned takes priority: if misaligned, set LAM/SAM only, never both.
- Exception path:
  - The request is accepted, there is no RAM access, and no store is performed.
  - State goes to RESP. RESP_V and the relevant flag assert for exactly one cycle at acceptance +1, regardless of LATENCY.
- Normal store:
  - RAM word off[..:3] is written at the acceptance edge.
  - Byte lanes are selected by off[2:0] and REQ_SIZE; the other bytes are preserved.
  - RESP_V pulses at acceptance + LATENCY with RDATA = 0.
- Normal load:
  - The word is read and the lane is extracted and extended: sign-extended unless REQ_UNSIGNED or size = double.
  - The result is registered; RESP_V pulses at acceptance + LATENCY.
  - A store-then-load to the same word returns the new data.
- State machine IDLE → BUSY → RESP → IDLE:
  - IDLE→BUSY on accept when normal and LATENCY > 1. The counter loads LATENCY−1 and decrements; BUSY→RESP when the counter reaches 1.
  - IDLE→RESP directly on accept when normal with LATENCY = 1, or on any exception.
  - RESP drives RESP_V = 1 for one cycle, then returns to IDLE. REQ_READY is 0 in RESP, so the next accept is at the earliest in the cycle after RESP.
- FLUSH:
  - In BUSY or RESP: the state returns to IDLE next edge, RESP_V stays 0 (suppressed in the same cycle), and flags stay 0.
  - In IDLE: FLUSH blocks acceptance that cycle.
- Outputs other than REQ_READY are 0 whenever RESP_V = 0.

Decomposition:
- Shared package dmem_pkg:
  - SIZE_B/H/W/D encodings.
  - State enum IDLE/BUSY/RESP.
  - Function size_bytes(size).
- Sub-module dmem_lane_align, purely combinational:
  - Store path: merges REQ_WDATA into the old word using offset and size.
  - Load path: extracts the lane and sign/zero-extends it.
  - Instantiated once.

Test Plan:
- Reset with RESET_N = 0 for 2 cycles while REQ_V = 1 → REQ_READY = 1, RESP_V = 0, no write; a read of BASE returns the prior RAM value.
- Store double 0x8000_0000 data 0xFEDC_BA98_7654_3210, then load byte signed at 0x8000_0007 → RESP_V at accept+2, RDATA = 0xFFFF_FFFF_FFFF_FFFE. Unsigned half at 0x8000_0006 → 0x0000_0000_0000_FEDC.
- Load half at 0x8000_0001 → RESP_V at accept+1, MEM_LAM = 1, RDATA = 0. Store word at 0x8000_0002 → MEM_SAM = 1, RAM unchanged.
- Load double at BASE + DEPTH_WORDS*8 → MEM_LAF at accept+1. Store at 0x7FFF_FFF8 (below base) → MEM_SAF, no write.
- Store byte 0xAB at 0x8000_0003, then FLUSH during BUSY → no RESP_V, REQ_READY = 1 next cycle; a subsequent load double at 0x8000_0000 shows byte 3 = 0xAB.
- Two requests with REQ_V held high → accepts spaced LATENCY+1 cycles apart, with one RESP_V per request in order.
